// File: rtl/shift_register_universal_if.sv
// Operand-register bus: control and data from the datapath, register contents and flags back.
interface shift_register_universal_if #(
  parameter int unsigned WIDTH = 8
);
  localparam int unsigned SHW = $clog2(WIDTH);

  logic             en;
  logic [2:0]       mode;
  logic [SHW-1:0]   shamt;
  logic             ser_in;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic             carry_out;
  logic             zero;

  // Datapath side: issues operations, observes the register.
  modport master (
    output en, mode, shamt, ser_in, d,
    input  q, carry_out, zero
  );

  // Register side.
  modport slave (
    input  en, mode, shamt, ser_in, d,
    output q, carry_out, zero
  );
endinterface

// File: rtl/shift_register_universal.sv
// Universal operand/result register: load, clear, shift, rotate and arithmetic shift right
// by a variable amount in one clock, with registered carry-out and a combinational zero flag.
module shift_register_universal #(
  parameter int unsigned      WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input logic                        clk,
  input logic                        rst_n,
  shift_register_universal_if.slave  bus
);
  localparam int unsigned SHW = $clog2(WIDTH);

  typedef enum logic [2:0] {
    ModeHold  = 3'b000,
    ModeLoad  = 3'b001,
    ModeShl   = 3'b010,
    ModeShr   = 3'b011,
    ModeRol   = 3'b100,
    ModeRor   = 3'b101,
    ModeAsr   = 3'b110,
    ModeClear = 3'b111
  } mode_e;

  logic [WIDTH-1:0] q_q, q_d;
  logic             carry_q, carry_d;

  mode_e            mode;
  int unsigned      amt;
  logic             shift_ok;
  logic [SHW-1:0]   hi_idx;
  logic [SHW-1:0]   lo_idx;
  logic [WIDTH-1:0] ones;
  logic [WIDTH-1:0] lo_fill;
  logic [WIDTH-1:0] hi_fill;
  logic [WIDTH-1:0] sign_fill;

  // Decode the shift amount; out-of-range amounts (non power-of-2 widths) behave as zero.
  always_comb begin
    mode      = mode_e'(bus.mode);
    amt       = 32'(bus.shamt);
    shift_ok  = (amt != 0) && (amt < WIDTH);
    // Bit positions that leave the register for left and right moves respectively.
    hi_idx    = SHW'(WIDTH - amt);
    lo_idx    = SHW'(amt - 1);
    ones      = '1;
    lo_fill   = bus.ser_in ? ~(ones << amt) : '0;
    hi_fill   = bus.ser_in ? ~(ones >> amt) : '0;
    sign_fill = q_q[WIDTH-1] ? ~(ones >> amt) : '0;
  end

  // Next-state selection; hold is the default for every path not named below.
  always_comb begin
    q_d     = q_q;
    carry_d = carry_q;
    if (bus.en) begin
      case (mode)
        ModeHold: begin
          q_d     = q_q;
          carry_d = carry_q;
        end
        ModeLoad: begin
          q_d     = bus.d;
          carry_d = 1'b0;
        end
        ModeShl: begin
          if (shift_ok) begin
            q_d     = (q_q << amt) | lo_fill;
            carry_d = q_q[hi_idx];
          end
        end
        ModeShr: begin
          if (shift_ok) begin
            q_d     = (q_q >> amt) | hi_fill;
            carry_d = q_q[lo_idx];
          end
        end
        ModeRol: begin
          if (shift_ok) begin
            q_d     = (q_q << amt) | (q_q >> (WIDTH - amt));
            carry_d = q_q[hi_idx];
          end
        end
        ModeRor: begin
          if (shift_ok) begin
            q_d     = (q_q >> amt) | (q_q << (WIDTH - amt));
            carry_d = q_q[lo_idx];
          end
        end
        ModeAsr: begin
          if (shift_ok) begin
            q_d     = (q_q >> amt) | sign_fill;
            carry_d = q_q[lo_idx];
          end
        end
        ModeClear: begin
          q_d     = '0;
          carry_d = 1'b0;
        end
        default: begin
          q_d     = q_q;
          carry_d = carry_q;
        end
      endcase
    end
  end

  // State register with synchronous active-low reset taking priority over any operation.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_q     <= RESET_VAL;
      carry_q <= 1'b0;
    end else begin
      q_q     <= q_d;
      carry_q <= carry_d;
    end
  end

  // Zero flag is derived straight from the register so it tracks Q in the same cycle.
  always_comb begin
    bus.q         = q_q;
    bus.carry_out = carry_q;
    bus.zero      = (q_q == '0);
  end
endmodule

// File: tb/tb_shift_register_universal.sv
// Bench for the universal register: directed scenarios then random operations against an
// arithmetic reference model.
module tb_shift_register_universal;
  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  int   mq;
  int   mc;

  shift_register_universal_if #(.WIDTH(8)) sr_if ();

  shift_register_universal #(
    .WIDTH     (8),
    .RESET_VAL (8'h00)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sr_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: 8-bit value treated as an integer, shifts as multiply/divide by 2**n.
  task automatic model(input int r, input int e, input int m, input int n, input int s,
                       input int dv);
    int p;
    int lo;
    int hi;
    if (r == 0) begin
      mq = 0;
      mc = 0;
    end else if (e != 0) begin
      p  = 1 << n;
      lo = (s != 0) ? p - 1 : 0;
      hi = 256 - 256 / p;
      case (m)
        1: begin mq = dv % 256; mc = 0; end
        7: begin mq = 0; mc = 0; end
        2, 3, 4, 5, 6: begin
          if (n != 0) begin
            if (m == 2 || m == 4) mc = (mq / (256 / p)) % 2;
            else                  mc = (mq / (p / 2)) % 2;
            case (m)
              2: mq = (mq * p) % 256 + lo;
              3: mq = mq / p + ((s != 0) ? hi : 0);
              4: mq = (mq * p) % 256 + mq / (256 / p);
              5: mq = mq / p + (mq % p) * (256 / p);
              default: mq = mq / p + ((mq >= 128) ? hi : 0);
            endcase
          end
        end
        default: ;
      endcase
    end
  endtask

  // Apply one clock edge of stimulus, advance the model, then check all outputs.
  task automatic step(input string tag, input int r, input int e, input int m, input int n,
                      input int s, input int dv);
    rst_n        = (r != 0);
    sr_if.en     = (e != 0);
    sr_if.mode   = 3'(m);
    sr_if.shamt  = 3'(n);
    sr_if.ser_in = (s != 0);
    sr_if.d      = 8'(dv);
    model(r, e, m, n, s, dv);
    @(posedge clk);
    #1;
    chk({tag, ".q"}, sr_if.q, 8'(mq));
    chk({tag, ".carry"}, {7'd0, sr_if.carry_out}, 8'(mc));
    chk({tag, ".zero"}, {7'd0, sr_if.zero}, (mq == 0) ? 8'd1 : 8'd0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    mq    = 0;
    mc    = 0;
    @(negedge clk);

    // Reset wins over a load.
    step("rst", 0, 1, 1, 0, 0, 'hFF);
    chk("rst.q_const", sr_if.q, 8'h00);

    // Enable low holds through CLEAR requests.
    step("ld_a5", 1, 1, 1, 0, 0, 'hA5);
    for (int i = 0; i < 3; i++) step("en0_hold", 1, 0, 7, 0, 0, 0);
    chk("en0.q_const", sr_if.q, 8'hA5);
    step("clear", 1, 1, 7, 0, 0, 0);
    chk("clear.q_const", sr_if.q, 8'h00);

    step("ld_81", 1, 1, 1, 0, 0, 'h81);
    step("shl1", 1, 1, 2, 1, 0, 0);
    chk("shl1.q_const", sr_if.q, 8'h02);
    step("ld_81b", 1, 1, 1, 0, 0, 'h81);
    step("shr3", 1, 1, 3, 3, 1, 0);
    chk("shr3.q_const", sr_if.q, 8'hF0);

    step("ld_a5b", 1, 1, 1, 0, 0, 'hA5);
    step("rol4", 1, 1, 4, 4, 0, 0);
    chk("rol4.q_const", sr_if.q, 8'h5A);
    step("ld_01", 1, 1, 1, 0, 0, 'h01);
    step("ror1", 1, 1, 5, 1, 0, 0);
    chk("ror1.q_const", sr_if.q, 8'h80);

    step("ld_80", 1, 1, 1, 0, 0, 'h80);
    step("asr7", 1, 1, 6, 7, 0, 0);
    chk("asr7.q_const", sr_if.q, 8'hFF);
    step("ld_9e", 1, 1, 1, 0, 0, 'h9E);
    step("shl_to_3c", 1, 1, 2, 1, 0, 0);
    step("shl0", 1, 1, 2, 0, 1, 0);
    chk("shl0.q_const", sr_if.q, 8'h3C);
    chk("shl0.carry_const", {7'd0, sr_if.carry_out}, 8'd1);

    // Reset in the same edge as a rotate discards the rotate.
    step("ld_55", 1, 1, 1, 0, 0, 'h55);
    step("rol_rst", 0, 1, 4, 1, 0, 0);
    step("hold_after_rst", 1, 1, 0, 0, 0, 0);
    chk("rst_mid.q_const", sr_if.q, 8'h00);

    // Random operations.
    for (int i = 0; i < 400; i++) begin
      step("rand",
           ($urandom_range(0, 19) == 0) ? 0 : 1,
           ($urandom_range(0, 4) == 0) ? 0 : 1,
           int'($urandom_range(0, 7)),
           int'($urandom_range(0, 7)),
           int'($urandom_range(0, 1)),
           int'($urandom_range(0, 255)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
